ringbuf_pulse_fifo: RTL and testbench
=====================================

// Module: ringbuf_pulse_fifo
// PURPOSE
// - Ring-buffer FIFO directly downstream of the req->pulse/ack converter.
// - Each single-cycle push_pulse (one per CPU request) captures push_data into a circular store.
// - Entries drain to the AXI-lite master command path over a valid/ready interface.
// - Reports occupancy, full/empty and a sticky overflow flag back to the CPU side.
// PARAMETERS
// - DATA_W  32  width of one entry (command/data word)
// - ADDR_W   3  pointer width; DEPTH = 2**ADDR_W entries (min 1)
// PORTS
// - clk           in   1        single clock; all logic on posedge clk
// - rstn          in   1        reset, asynchronous, active-low
// - push_pulse    in   1        one-cycle write strobe (from pulse converter)
// - push_data     in   DATA_W   entry sampled when push_pulse=1
// - flush         in   1        synchronous clear of contents and overflow flag
// - clr_overflow  in   1        synchronous clear of the overflow flag
// - m_valid       out  1        head entry available
// - m_data        out  DATA_W   head entry (first-word fall-through)
// - m_ready       in   1        consumer accepts head when m_valid & m_ready
// - full          out  1        count == DEPTH
// - empty         out  1        count == 0
// - count         out  ADDR_W+1 occupancy, 0..DEPTH
// - overflow      out  1        sticky: at least one push lost an entry
// BEHAVIOUR
// - Reset (rstn=0, async): wr_ptr=rd_ptr=0, count=0, overflow=0.
//   - Outputs: m_valid=0, empty=1, full=0.
//   - Storage array is not reset; m_data is don't-care while m_valid=0.
// - Pointers: ADDR_W+1 bits with an extra wrap bit.
//   - empty = (wr_ptr==rd_ptr).
//   - full  = MSBs differ, low ADDR_W bits equal.
//   - Increment is modulo 2**(ADDR_W+1); DEPTH-1 -> 0 wraps cleanly.
// - pop  = m_valid & m_ready.  m_valid = ~empty.  m_data = mem[rd_ptr[ADDR_W-1:0]].
// - push = push_pulse & (~full | pop).
//   - Writes mem[wr_ptr] and advances wr_ptr.
// - Latency: push accepted in cycle N -> m_valid=1 and m_data valid in cycle N+1.
//   - No same-cycle bypass; empty FIFO plus push gives no pop that cycle.
// - Simultaneous push & pop: both pointers advance, count unchanged. Legal when full.
// - count updates each cycle by +push -pop; it is a register, never combinational.
// - While m_valid=1 and m_ready=0, m_data stays stable (except the overwrite case below).
// - Push while full and no pop: the entry is lost; overflow<=1 (sticky).
//   - Same-cycle overflow event and clr_overflow: set wins.
// - flush: next cycle wr_ptr=rd_ptr=0, count=0, overflow=0.
//   - Overrides push and pop issued in the same cycle.
// - push_pulse held >1 cycle is treated as multiple pushes; upstream guarantees single pulses.
// CONFIGURATION
// - Macro RINGBUF_OVERWRITE_EN.
// - Undefined (default): push while full and no pop is dropped.
//   - Storage and pointers are unchanged; overflow is set.
// - Defined: push while full and no pop overwrites the oldest entry.
//   - Writes mem[wr_ptr]; advances wr_ptr and rd_ptr together; count stays DEPTH; overflow is set.
//   - m_data may change while m_valid=1 and m_ready=0. The consumer samples only on handshake.
// TESTING
// - Reset, then 3 pushes (0xA1,0xA2,0xA3) with m_ready=0.
//   -> count=3, m_valid=1, m_data=0xA1 from the cycle after the 1st push.
//   -> then m_ready=1 drains A1,A2,A3 in order; empty=1 after.
// - Fill DEPTH=8 entries, then push 0xFF with m_ready=0.
//   -> full=1, count=8, overflow=1.
//   -> default: drain yields entries 0..7 unchanged.
//   -> OVERWRITE_EN: drain yields entries 1..7 then 0xFF.
// - Full FIFO, push_pulse and m_ready both 1 in the same cycle.
//   -> count stays 8, overflow stays 0, new word appears last in drain order.
// - Push/pop 20 entries continuously with DEPTH=8.
//   -> pointers wrap twice, order preserved, no false full or empty.
// - Overflow sticky: set overflow, then assert clr_overflow alone -> 0 next cycle.
//   -> overflow event and clr_overflow in the same cycle -> overflow stays 1.
// - rstn low mid-drain with count=5 -> immediately count=0, m_valid=0, overflow=0.
//   -> flush with count=4 plus a same-cycle push -> count=0 next cycle.

Source files
------------

// File: rtl/ringbuf_pulse_fifo_if.sv
// Push/drain signal bundle for ringbuf_pulse_fifo: the CPU-side push strobe and
// status flags, plus the valid/ready drain toward the AXI-lite command path.
interface ringbuf_pulse_fifo_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 3
);
  logic              push_pulse;
  logic [DATA_W-1:0] push_data;
  logic              flush;
  logic              clr_overflow;
  logic              m_valid;
  logic [DATA_W-1:0] m_data;
  logic              m_ready;
  logic              full;
  logic              empty;
  logic [ADDR_W:0]   count;
  logic              overflow;

  modport master (
    output push_pulse, push_data, flush, clr_overflow, m_ready,
    input  m_valid, m_data, full, empty, count, overflow
  );

  modport slave (
    input  push_pulse, push_data, flush, clr_overflow, m_ready,
    output m_valid, m_data, full, empty, count, overflow
  );
endinterface

// File: rtl/ringbuf_pulse_fifo.sv
// Ring-buffer FIFO fed by single-cycle push pulses, drained over valid/ready with
// first-word fall-through. Define RINGBUF_OVERWRITE_EN to overwrite the oldest entry on overflow.
module ringbuf_pulse_fifo #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 3
) (
  input logic                clk,
  input logic                rstn,
  ringbuf_pulse_fifo_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W:0] wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
  logic [ADDR_W:0] count_r, count_nxt;
  logic            overflow_r, overflow_nxt;
  logic            empty_w, full_w;
  logic            pop, push, drop_evt, mem_we;

  // Extra wrap bit distinguishes full from empty when the low bits match.
  assign empty_w  = (wr_ptr == rd_ptr);
  assign full_w   = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                    (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
  assign pop      = ~empty_w & bus.m_ready;
  assign push     = bus.push_pulse & (~full_w | pop);
  assign drop_evt = bus.push_pulse & full_w & ~pop;

  always_comb begin
    wr_ptr_nxt   = wr_ptr;
    rd_ptr_nxt   = rd_ptr;
    count_nxt    = count_r;
    overflow_nxt = overflow_r;
    mem_we       = 1'b0;
    if (bus.flush) begin
      wr_ptr_nxt   = '0;
      rd_ptr_nxt   = '0;
      count_nxt    = '0;
      overflow_nxt = 1'b0;
    end else begin
      if (bus.clr_overflow) overflow_nxt = 1'b0;
      if (drop_evt)         overflow_nxt = 1'b1;
      if (push) begin
        mem_we     = 1'b1;
        wr_ptr_nxt = wr_ptr + 1'b1;
      end
      if (pop) rd_ptr_nxt = rd_ptr + 1'b1;
      if (push && !pop)      count_nxt = count_r + 1'b1;
      else if (pop && !push) count_nxt = count_r - 1'b1;
`ifdef RINGBUF_OVERWRITE_EN
      // Oldest entry is sacrificed: both pointers step so occupancy stays DEPTH.
      if (drop_evt) begin
        mem_we     = 1'b1;
        wr_ptr_nxt = wr_ptr + 1'b1;
        rd_ptr_nxt = rd_ptr + 1'b1;
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_r    <= '0;
      overflow_r <= 1'b0;
    end else begin
      wr_ptr     <= wr_ptr_nxt;
      rd_ptr     <= rd_ptr_nxt;
      count_r    <= count_nxt;
      overflow_r <= overflow_nxt;
    end
  end

  // Storage holds data only, so it is left out of reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_ptr[ADDR_W-1:0]] <= bus.push_data;
  end

  assign bus.m_valid  = ~empty_w;
  assign bus.m_data   = mem[rd_ptr[ADDR_W-1:0]];
  assign bus.full     = full_w;
  assign bus.empty    = empty_w;
  assign bus.count    = count_r;
  assign bus.overflow = overflow_r;
endmodule

// File: tb/tb_ringbuf_pulse_fifo.sv
// Directed bench for ringbuf_pulse_fifo (DEPTH=8); expected drain order follows RINGBUF_OVERWRITE_EN.
module tb_ringbuf_pulse_fifo;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 3;
  localparam int DEPTH  = 8;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  int   checks = 0;
  int   errors = 0;

  ringbuf_pulse_fifo_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus();

  ringbuf_pulse_fifo #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.push_pulse   = 1'b0;
    bus.push_data    = '0;
    bus.flush        = 1'b0;
    bus.clr_overflow = 1'b0;
    bus.m_ready      = 1'b0;
  endtask

  task automatic push_word(input logic [31:0] d);
    bus.push_pulse = 1'b1;
    bus.push_data  = d;
    tick();
    bus.push_pulse = 1'b0;
  endtask

  task automatic fill(input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) push_word(base + i);
  endtask

  task automatic do_flush();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rstn = 1'b0;
    repeat (2) tick();
    checks++; if (bus.m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid got=%b exp=0", bus.m_valid); end
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL reset_empty got=%b exp=1", bus.empty); end
    checks++; if (bus.full !== 1'b0) begin errors++; $display("FAIL reset_full got=%b exp=0", bus.full); end
    checks++; if (bus.count !== 4'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", bus.count); end
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got=%b exp=0", bus.overflow); end
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    logic [31:0] exp;
    bus.m_ready    = 1'b0;
    bus.push_pulse = 1'b1;
    bus.push_data  = 32'hA1;
    #1;
    checks++; if (bus.m_valid !== 1'b0) begin errors++; $display("FAIL basic_no_bypass got=%b exp=0", bus.m_valid); end
    tick();
    bus.push_pulse = 1'b0;
    checks++; if (bus.m_valid !== 1'b1) begin errors++; $display("FAIL basic_latency_valid got=%b exp=1", bus.m_valid); end
    checks++; if (bus.m_data !== 32'hA1) begin errors++; $display("FAIL basic_latency_data got=%h exp=a1", bus.m_data); end
    checks++; if (bus.count !== 4'd1) begin errors++; $display("FAIL basic_count1 got=%0d exp=1", bus.count); end
    push_word(32'hA2);
    push_word(32'hA3);
    checks++; if (bus.count !== 4'd3) begin errors++; $display("FAIL basic_count3 got=%0d exp=3", bus.count); end
    checks++; if (bus.m_data !== 32'hA1) begin errors++; $display("FAIL basic_head_stable got=%h exp=a1", bus.m_data); end
    bus.m_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      exp = 32'hA1 + i;
      checks++; if (bus.m_data !== exp) begin errors++; $display("FAIL basic_drain%0d got=%h exp=%h", i, bus.m_data, exp); end
      tick();
    end
    bus.m_ready = 1'b0;
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL basic_empty_after got=%b exp=1", bus.empty); end
    checks++; if (bus.count !== 4'd0) begin errors++; $display("FAIL basic_count0 got=%0d exp=0", bus.count); end
  endtask

  task automatic test_overflow();
    logic [31:0] exp;
    do_flush();
    fill(DEPTH, 32'h10);
    checks++; if (bus.full !== 1'b1) begin errors++; $display("FAIL ovf_full_before got=%b exp=1", bus.full); end
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL ovf_flag_before got=%b exp=0", bus.overflow); end
    push_word(32'hFF);
    checks++; if (bus.full !== 1'b1) begin errors++; $display("FAIL ovf_full_after got=%b exp=1", bus.full); end
    checks++; if (bus.count !== 4'd8) begin errors++; $display("FAIL ovf_count got=%0d exp=8", bus.count); end
    checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag_set got=%b exp=1", bus.overflow); end
    bus.m_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
`ifdef RINGBUF_OVERWRITE_EN
      exp = (i < DEPTH - 1) ? 32'h11 + i : 32'hFF;
`else
      exp = 32'h10 + i;
`endif
      checks++; if (bus.m_valid !== 1'b1 || bus.m_data !== exp) begin errors++; $display("FAIL ovf_drain%0d got=%b/%h exp=1/%h", i, bus.m_valid, bus.m_data, exp); end
      tick();
    end
    bus.m_ready = 1'b0;
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL ovf_empty_after got=%b exp=1", bus.empty); end
    checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got=%b exp=1", bus.overflow); end
  endtask

  task automatic test_overflow_clear();
    bus.clr_overflow = 1'b1;
    tick();
    bus.clr_overflow = 1'b0;
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL clr_alone got=%b exp=0", bus.overflow); end
    fill(DEPTH, 32'h60);
    bus.push_pulse   = 1'b1;
    bus.push_data    = 32'h77;
    bus.clr_overflow = 1'b1;
    tick();
    bus.push_pulse   = 1'b0;
    bus.clr_overflow = 1'b0;
    checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL clr_set_wins got=%b exp=1", bus.overflow); end
    do_flush();
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL flush_clears_ovf got=%b exp=0", bus.overflow); end
    checks++; if (bus.count !== 4'd0) begin errors++; $display("FAIL flush_count got=%0d exp=0", bus.count); end
  endtask

  task automatic test_full_push_pop();
    logic [31:0] exp;
    do_flush();
    fill(DEPTH, 32'h20);
    bus.push_pulse = 1'b1;
    bus.push_data  = 32'h30;
    bus.m_ready    = 1'b1;
    tick();
    bus.push_pulse = 1'b0;
    checks++; if (bus.count !== 4'd8) begin errors++; $display("FAIL fpp_count got=%0d exp=8", bus.count); end
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL fpp_overflow got=%b exp=0", bus.overflow); end
    checks++; if (bus.full !== 1'b1) begin errors++; $display("FAIL fpp_full got=%b exp=1", bus.full); end
    for (int i = 0; i < DEPTH; i++) begin
      exp = (i < DEPTH - 1) ? 32'h21 + i : 32'h30;
      checks++; if (bus.m_data !== exp) begin errors++; $display("FAIL fpp_drain%0d got=%h exp=%h", i, bus.m_data, exp); end
      tick();
    end
    bus.m_ready = 1'b0;
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL fpp_empty got=%b exp=1", bus.empty); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp;
    do_flush();
    bus.m_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      bus.push_pulse = 1'b1;
      bus.push_data  = 32'h40 + i;
      if (i > 0) begin
        exp = 32'h40 + i - 1;
        checks++; if (bus.m_data !== exp) begin errors++; $display("FAIL b2b_data%0d got=%h exp=%h", i, bus.m_data, exp); end
        checks++; if (bus.count !== 4'd1 || bus.empty !== 1'b0 || bus.full !== 1'b0) begin errors++; $display("FAIL b2b_flags%0d got=cnt%0d/e%b/f%b exp=cnt1/e0/f0", i, bus.count, bus.empty, bus.full); end
      end
      tick();
    end
    bus.push_pulse = 1'b0;
    checks++; if (bus.m_data !== 32'h53) begin errors++; $display("FAIL b2b_last got=%h exp=53", bus.m_data); end
    tick();
    bus.m_ready = 1'b0;
    checks++; if (bus.empty !== 1'b1 || bus.count !== 4'd0) begin errors++; $display("FAIL b2b_end got=e%b/cnt%0d exp=e1/cnt0", bus.empty, bus.count); end
  endtask

  task automatic test_reset_mid();
    do_flush();
    fill(DEPTH, 32'h80);
    push_word(32'hEE);
    bus.m_ready = 1'b1;
    repeat (3) tick();
    checks++; if (bus.count !== 4'd5 || bus.overflow !== 1'b1) begin errors++; $display("FAIL rmid_pre got=cnt%0d/ovf%b exp=cnt5/ovf1", bus.count, bus.overflow); end
    #2;
    rstn = 1'b0;
    #1;
    checks++; if (bus.count !== 4'd0) begin errors++; $display("FAIL rmid_count got=%0d exp=0", bus.count); end
    checks++; if (bus.m_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid got=%b exp=0", bus.m_valid); end
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL rmid_overflow got=%b exp=0", bus.overflow); end
    bus.m_ready = 1'b0;
    tick();
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_flush();
    fill(4, 32'h90);
    checks++; if (bus.count !== 4'd4) begin errors++; $display("FAIL flush_pre got=%0d exp=4", bus.count); end
    bus.flush      = 1'b1;
    bus.push_pulse = 1'b1;
    bus.push_data  = 32'h99;
    bus.m_ready    = 1'b1;
    tick();
    idle_inputs();
    checks++; if (bus.count !== 4'd0) begin errors++; $display("FAIL flush_count got=%0d exp=0", bus.count); end
    checks++; if (bus.empty !== 1'b1 || bus.m_valid !== 1'b0) begin errors++; $display("FAIL flush_empty got=e%b/v%b exp=e1/v0", bus.empty, bus.m_valid); end
    push_word(32'h55);
    checks++; if (bus.m_data !== 32'h55 || bus.count !== 4'd1) begin errors++; $display("FAIL flush_after got=%h/cnt%0d exp=55/cnt1", bus.m_data, bus.count); end
    bus.m_ready = 1'b1;
    tick();
    bus.m_ready = 1'b0;
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL flush_final_empty got=%b exp=1", bus.empty); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_overflow_clear();
    test_full_push_pop();
    test_back_to_back();
    test_reset_mid();
    test_flush();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
